// File: rtl/loopyv_data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// loopyV_mem_types
// Shared types for the data-memory responder: load/store width encodings
// (funct3), the captured request and response records, and the FSM states.
// Optional build macro used by the responder files:
//   LOOPYV_DMEM_MISALIGN_TRAP_EN - report misaligned/illegal accesses on rsp_err
// ----------------------------------------------------------------------------
package loopyV_mem_types;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } DMemReqType;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } DMemRspType;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } DMemStateType;

endpackage

// File: rtl/loopyv_data_mem_responder_lsu_align.sv
// ----------------------------------------------------------------------------
// loopyv_lsu_align
// Combinational lane steering for the data-memory responder.
//   we          : 1 = store, 0 = load
//   addr_lo     : byte offset within the word (req_addr[1:0])
//   funct3      : access width / signedness
//   wdata       : store data (byte/half taken from the low bits)
//   rdata_word  : raw 32-bit word read from the array
//   byte_en     : per-lane write enables (all zero for loads and faults)
//   wdata_lanes : store data replicated onto every lane it may land in
//   load_data   : extracted and extended load result (zero for stores/faults)
//   fault       : illegal funct3, plus misalignment when
//                 LOOPYV_DMEM_MISALIGN_TRAP_EN is defined
// ----------------------------------------------------------------------------
module loopyv_lsu_align
    import loopyV_mem_types::*;
(
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data,
    output logic        fault
);

    logic        illegal;
    logic        misalign;
    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can leave a latch behind.
    always_comb begin
        illegal     = 1'b0;
        misalign    = 1'b0;
        byte_en     = 4'b0000;
        wdata_lanes = wdata;
        shifted     = rdata_word;
        load_data   = 32'h0;

        // Unsigned widths only exist for loads.
        case (funct3)
            MEM_B, MEM_H, MEM_W: illegal = 1'b0;
            MEM_BU, MEM_HU:      illegal = we;
            default:             illegal = 1'b1;
        endcase

`ifdef LOOPYV_DMEM_MISALIGN_TRAP_EN
        misalign = (((funct3 == MEM_H) || (funct3 == MEM_HU)) && addr_lo[0]) ||
                   ((funct3 == MEM_W) && (addr_lo != 2'b00));
`endif
        fault = illegal | misalign;

        // Without trapping, a half ignores addr[0] and a word ignores addr[1:0].
        case (funct3)
            MEM_B, MEM_BU: begin
                byte_en     = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                shifted     = rdata_word >> {addr_lo, 3'b000};
            end
            MEM_H, MEM_HU: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                shifted     = rdata_word >> {addr_lo[1], 4'b0000};
            end
            MEM_W:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase

        case (funct3)
            MEM_B:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_BU:  load_data = {24'h0, shifted[7:0]};
            MEM_H:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_HU:  load_data = {16'h0, shifted[15:0]};
            MEM_W:   load_data = shifted;
            default: load_data = 32'h0;
        endcase

        if (!we || fault) byte_en   = 4'b0000;
        if (we || fault)  load_data = 32'h0;
    end

endmodule

// File: rtl/loopyv_data_mem_responder.sv
// ----------------------------------------------------------------------------
// loopyv_data_mem_responder
// Target-side data RAM for the MEM stage. One request at a time is accepted
// over req_valid/req_ready, held for WAIT_STATES cycles, then committed to
// (store) or read from (load) the array on the edge entering RESP. The
// response is held until rsp_ready.
//   clk, reset            : clock (rising edge), async active-high reset
//   req_valid/req_ready   : request handshake
//   req_we/addr/funct3/wdata : request payload
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : extended load data, 0 for stores/illegal accesses
//   rsp_err               : fault flag, driven only with
//                           LOOPYV_DMEM_MISALIGN_TRAP_EN defined, else 0
// ----------------------------------------------------------------------------
module loopyv_data_mem_responder
    import loopyV_mem_types::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW          = $clog2(DEPTH_WORDS);
    localparam int         WAIT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] WAIT_INIT   = WAIT_INIT_I[3:0];

    DMemStateType state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    DMemReqType   req_q, req_d;
    DMemRspType   rsp_q, rsp_d;

    DMemReqType   cur_req;
    logic [AW-1:0] word_idx;
    logic         enter_resp;
    logic         do_write;

    logic [3:0]   byte_en;
    logic [31:0]  wdata_lanes;
    logic [31:0]  load_data;
    logic         fault;

    logic [31:0]  mem [DEPTH_WORDS];

    // In IDLE with no wait states the access happens on the accept edge, so
    // the live request is used; otherwise the captured copy is.
    always_comb begin
        if (state_q == IDLE) begin
            cur_req.we     = req_we;
            cur_req.addr   = req_addr;
            cur_req.funct3 = req_funct3;
            cur_req.wdata  = req_wdata;
        end else begin
            cur_req = req_q;
        end
    end

    // Address bits above the array wrap silently.
    assign word_idx = cur_req.addr[AW+1:2];

    loopyv_lsu_align u_align (
        .we          (cur_req.we),
        .addr_lo     (cur_req.addr[1:0]),
        .funct3      (cur_req.funct3),
        .wdata       (cur_req.wdata),
        .rdata_word  (mem[word_idx]),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .load_data   (load_data),
        .fault       (fault)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        rsp_d      = rsp_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = cur_req;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            rsp_d.rdata = load_data;
`ifdef LOOPYV_DMEM_MISALIGN_TRAP_EN
            rsp_d.err   = fault;
`else
            rsp_d.err   = 1'b0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
        end
    end

    // A store still in WAIT when reset hits never reaches this point.
    assign do_write = enter_resp & ~reset;

    // NOTE: the storage array has no reset so it maps onto block RAM; its
    // contents are undefined until written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cur_req.addr[31:AW+2], fault};

endmodule

// File: tb/tb_loopyv_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_loopyv_data_mem_responder
// Directed bench. Instance 0 has no wait states, instance 1 has three.
// Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_loopyv_data_mem_responder;
    import loopyV_mem_types::*;

    logic        clk = 1'b0;
    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    int vectors = 0;
    int errors  = 0;

`ifdef LOOPYV_DMEM_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    always #5 clk = ~clk;

    loopyv_data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_funct3(req_funct3[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    loopyv_data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_funct3(req_funct3[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full transaction on instance d; response is held for 'hold' cycles
    // with rsp_ready low before being taken.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd, input int hold,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int lat;
        int n;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = addr;
        req_funct3[d] = f3;
        req_wdata[d]  = wd;
        rsp_ready[d]  = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, (d == 0) ? 32'd1 : 32'd4);
        check({tag, "_rdata"}, rsp_rdata[d], exp_rd);
        check({tag, "_err"}, {31'h0, rsp_err[d]}, {31'h0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, {31'h0, rsp_valid[d]}, 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata[d], exp_rd);
            check({tag, "_hold_ready"}, {31'h0, req_ready[d]}, 32'd0);
        end
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        check({tag, "_done_valid"}, {31'h0, rsp_valid[d]}, 32'd0);
        check({tag, "_done_ready"}, {31'h0, req_ready[d]}, 32'd1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d]      = 1'b1;
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = 32'h0;
            req_funct3[d] = MEM_W;
            req_wdata[d]  = 32'h0;
            rsp_ready[d]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_req_ready", {31'h0, req_ready[d]}, 32'd1);
            check("reset_rsp_valid", {31'h0, rsp_valid[d]}, 32'd0);
            check("reset_rsp_rdata", rsp_rdata[d], 32'h0);
            check("reset_rsp_err",   {31'h0, rsp_err[d]}, 32'd0);
        end
        @(negedge clk);
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Zero wait states: basic word, byte and half traffic.
        txn(0, 1'b1, 32'h10, MEM_W,  32'hDEADBEEF, 0, 32'h0,        1'b0, "sw_10");
        txn(0, 1'b0, 32'h10, MEM_W,  32'h0,        0, 32'hDEADBEEF, 1'b0, "lw_10");
        txn(0, 1'b1, 32'h11, MEM_B,  32'h000000A5, 0, 32'h0,        1'b0, "sb_11");
        txn(0, 1'b0, 32'h10, MEM_W,  32'h0,        0, 32'hDEADA5EF, 1'b0, "lw_after_sb");
        txn(0, 1'b0, 32'h11, MEM_B,  32'h0,        0, 32'hFFFFFFA5, 1'b0, "lb_11");
        txn(0, 1'b0, 32'h11, MEM_BU, 32'h0,        0, 32'h000000A5, 1'b0, "lbu_11");
        txn(0, 1'b0, 32'h12, MEM_H,  32'h0,        0, 32'hFFFFDEAD, 1'b0, "lh_12");
        txn(0, 1'b0, 32'h12, MEM_HU, 32'h0,        0, 32'h0000DEAD, 1'b0, "lhu_12");
        txn(0, 1'b0, 32'h13, MEM_B,  32'h0,        0, 32'hFFFFFFDE, 1'b0, "lb_13");
        txn(0, 1'b1, 32'h10, MEM_H,  32'hABCD7777, 0, 32'h0,        1'b0, "sh_10");
        txn(0, 1'b0, 32'h10, MEM_W,  32'h0,        0, 32'hDEAD7777, 1'b0, "lw_after_sh");

        // Address wrap modulo 4*DEPTH_WORDS.
        txn(0, 1'b1, 32'h1000, MEM_W, 32'h12345678, 0, 32'h0,        1'b0, "sw_wrap");
        txn(0, 1'b0, 32'h0000, MEM_W, 32'h0,        0, 32'h12345678, 1'b0, "lw_wrap");

        // Illegal widths never write and always return zero.
        txn(0, 1'b1, 32'h10, 3'b011, 32'h0,        0, 32'h0,        TRAP, "s_f3_011");
        txn(0, 1'b1, 32'h10, MEM_BU, 32'h0,        0, 32'h0,        TRAP, "s_f3_100");
        txn(0, 1'b0, 32'h10, 3'b110, 32'h0,        0, 32'h0,        TRAP, "l_f3_110");
        txn(0, 1'b0, 32'h10, MEM_W,  32'h0,        0, 32'hDEAD7777, 1'b0, "lw_after_illegal");

        // Misaligned word store and half load.
        txn(0, 1'b1, 32'h20, MEM_W,  32'h11111111, 0, 32'h0,        1'b0, "sw_20");
        txn(0, 1'b1, 32'h22, MEM_W,  32'hFFFFFFFF, 0, 32'h0,        TRAP, "sw_22_mis");
        txn(0, 1'b0, 32'h20, MEM_W,  32'h0,        0,
            TRAP ? 32'h11111111 : 32'hFFFFFFFF, 1'b0, "lw_20_after_mis");
        txn(0, 1'b0, 32'h21, MEM_H,  32'h0,        0,
            TRAP ? 32'h0 : 32'hFFFFFFFF, TRAP, "lh_21_mis");

        // Three wait states with a stalled response.
        txn(1, 1'b1, 32'h40, MEM_W, 32'h55AA55AA, 5, 32'h0,        1'b0, "ws3_sw_40");
        txn(1, 1'b0, 32'h40, MEM_W, 32'h0,        5, 32'h55AA55AA, 1'b0, "ws3_lw_40");

        // Reset during WAIT drops the uncommitted store.
        txn(1, 1'b1, 32'h30, MEM_W, 32'h0BADBEEF, 0, 32'h0, 1'b0, "ws3_sw_30");
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_addr[1]   = 32'h30;
        req_funct3[1] = MEM_W;
        req_wdata[1]  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("mid_wait_ready", {31'h0, req_ready[1]}, 32'd0);
        @(posedge clk);
        #2;
        reset[1] = 1'b1;
        #1;
        check("async_rst_valid", {31'h0, rsp_valid[1]}, 32'd0);
        check("async_rst_ready", {31'h0, req_ready[1]}, 32'd1);
        @(negedge clk);
        reset[1] = 1'b0;
        txn(1, 1'b0, 32'h30, MEM_W, 32'h0, 0, 32'h0BADBEEF, 1'b0, "ws3_lw_30_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
